// File: rtl/instr_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// The queue entry carries the fetched PC, the raw instruction word,
// the branch predictor's verdict and the call/return hints used by the RAS.
package instr_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT = 8;
    localparam int XLEN             = 32;

    typedef logic [XLEN-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        logic  taken;
        addr_t target;
    } branch_predict_t;

    typedef struct packed {
        addr_t           pc;
        logic [31:0]     instr;
        branch_predict_t bp_info;
        logic            is_ret;
        logic            is_call;
    } iq_entry_t;

    // Number of entries offered by a two-slot valid vector. Slot 1 only
    // counts when slot 0 is also valid, so "10" contributes nothing.
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        if (!v[0]) begin
            return 2'd0;
        end
        return v[1] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/instr_queue_perf.sv
// Saturating occupancy counters for the instruction queue.
// Only compiled when IQ_PERF_EN is defined; otherwise the queue ties its
// counter outputs to zero and this module does not exist in the build.
`ifdef IQ_PERF_EN
module iq_perf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        is_empty,
    input  logic        is_full,
    output logic [31:0] empty_cycles,
    output logic [31:0] full_cycles
);

    logic [31:0] empty_cycles_q, empty_cycles_d;
    logic [31:0] full_cycles_q,  full_cycles_d;

    // Count qualifying cycles, holding at all-ones instead of wrapping.
    always_comb begin
        empty_cycles_d = empty_cycles_q;
        full_cycles_d  = full_cycles_q;
        if (is_empty && (empty_cycles_q != 32'hFFFF_FFFF)) begin
            empty_cycles_d = empty_cycles_q + 32'd1;
        end
        if (is_full && (full_cycles_q != 32'hFFFF_FFFF)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end
    end

    // Counter registers; only reset clears them, a queue flush does not.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            empty_cycles_q <= '0;
            full_cycles_q  <= '0;
        end else begin
            empty_cycles_q <= empty_cycles_d;
            full_cycles_q  <= full_cycles_d;
        end
    end

    assign empty_cycles = empty_cycles_q;
    assign full_cycles  = full_cycles_q;

endmodule
`endif

// File: rtl/instr_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Circular flop array with separate head/tail pointers and an explicit
// occupancy count (full is count == DEPTH, never pointer equality).
// Optional occupancy counters are built when IQ_PERF_EN is defined.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [1:0]      in_valid,
    input  iq_entry_t [1:0] in_entry,
    output logic            in_ready,
    output logic [1:0]      out_valid,
    output iq_entry_t [1:0] out_entry,
    input  logic [1:0]      out_pop,
    input  logic            flush,
    output logic [31:0]     empty_cycles,
    output logic [31:0]     full_cycles
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    iq_entry_t     mem_q [DEPTH];
    iq_entry_t     mem_d [DEPTH];

    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    logic          push_ok;
    logic          pop0;
    logic          pop1;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;

    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    // Handshake outputs depend only on the registered count and flush, so
    // decode's pop decision never feeds back into fetch's ready.
    always_comb begin
        in_ready  = (count_q <= (DEPTH_C - CW'(2)));
        out_valid = 2'b00;
        if (!flush) begin
            out_valid[0] = (count_q >= CW'(1));
            out_valid[1] = (count_q >= CW'(2));
        end
    end

    // Present the two oldest entries; invalid slots read as zero.
    always_comb begin
        out_entry[0] = out_valid[0] ? mem_q[head_q]  : '0;
        out_entry[1] = out_valid[1] ? mem_q[head_p1] : '0;
    end

    // Accepted push and pop amounts. A "10" pop is not contiguous and is
    // dropped; push eligibility looks only at the pre-pop count.
    always_comb begin
        push_ok = in_ready && !flush;
        n_push  = push_ok ? slot_count(in_valid) : 2'd0;
        pop0    = out_pop[0] && out_valid[0];
        pop1    = out_pop[0] && out_pop[1] && out_valid[1];
        n_pop   = {1'b0, pop0} + {1'b0, pop1};
    end

    // Next pointers, count and storage; flush wins over push and pop.
    always_comb begin
        head_d  = head_q + PW'(n_pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(n_pop);
        mem_d   = mem_q;
        if (n_push != 2'd0) begin
            mem_d[tail_q] = in_entry[0];
        end
        if (n_push == 2'd2) begin
            mem_d[tail_p1] = in_entry[1];
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State registers; reset overrides push, pop and flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

`ifdef IQ_PERF_EN
    logic perf_empty;
    logic perf_full;

    assign perf_empty = (count_q == '0);
    assign perf_full  = !in_ready;

    iq_perf u_perf (
        .clk          (clk),
        .resetn       (resetn),
        .is_empty     (perf_empty),
        .is_full      (perf_full),
        .empty_cycles (empty_cycles),
        .full_cycles  (full_cycles)
    );
`else
    assign empty_cycles = '0;
    assign full_cycles  = '0;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [1:0]      in_valid;
    iq_entry_t [1:0] in_entry;
    logic            in_ready;
    logic [1:0]      out_valid;
    iq_entry_t [1:0] out_entry;
    logic [1:0]      out_pop;
    logic            flush;
    logic [31:0]     empty_cycles;
    logic [31:0]     full_cycles;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_entry     (in_entry),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_entry    (out_entry),
        .out_pop      (out_pop),
        .flush        (flush),
        .empty_cycles (empty_cycles),
        .full_cycles  (full_cycles)
    );

    always #5 clk = ~clk;

    iq_entry_t   model_q[$];
    logic [31:0] m_empty;
    logic [31:0] m_full;
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          seq_chk = 0;
    logic [31:0] next_pc_exp;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic iq_entry_t mk_entry(input logic [31:0] pc);
        iq_entry_t e;
        e.pc             = pc;
        e.instr          = $urandom;
        e.bp_info.valid  = 1'($urandom_range(0, 1));
        e.bp_info.taken  = 1'($urandom_range(0, 1));
        e.bp_info.target = $urandom;
        e.is_ret         = 1'($urandom_range(0, 1));
        e.is_call        = 1'($urandom_range(0, 1));
        return e;
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic check_all(input string tag);
        int          sz;
        logic [1:0]  ev;
        logic        er;
        iq_entry_t   e0;
        iq_entry_t   e1;
        sz = model_q.size();
        ev = flush ? 2'b00 : {sz >= 2, sz >= 1};
        er = (DEPTH - sz) >= 2;
        e0 = ev[0] ? model_q[0] : '0;
        e1 = ev[1] ? model_q[1] : '0;
        chk({tag, ".in_ready"},  128'(in_ready),     128'(er));
        chk({tag, ".out_valid"}, 128'(out_valid),    128'(ev));
        chk({tag, ".entry0"},    128'(out_entry[0]), 128'(e0));
        chk({tag, ".entry1"},    128'(out_entry[1]), 128'(e1));
`ifdef IQ_PERF_EN
        chk({tag, ".empty_cyc"}, 128'(empty_cycles), 128'(m_empty));
        chk({tag, ".full_cyc"},  128'(full_cycles),  128'(m_full));
`else
        chk({tag, ".empty_cyc"}, 128'(empty_cycles), 128'(0));
        chk({tag, ".full_cyc"},  128'(full_cycles),  128'(0));
`endif
    endtask

    // One clock cycle: drive inputs at negedge, check, advance the model,
    // and return at the following negedge.
    task automatic step(input string tag, input logic rst_n, input logic [1:0] iv,
                        input iq_entry_t a, input iq_entry_t b,
                        input logic [1:0] pop, input logic fl);
        int sz;
        int np;
        bit rdy;
        resetn      = rst_n;
        in_valid    = iv;
        in_entry[0] = a;
        in_entry[1] = b;
        out_pop     = pop;
        flush       = fl;
        #1;
        check_all(tag);
        sz  = model_q.size();
        rdy = (DEPTH - sz) >= 2;
        np  = 0;
        if (!fl) begin
            if (pop[0] && sz >= 1) np++;
            if (pop == 2'b11 && sz >= 2) np++;
        end
        if (seq_chk && rst_n) begin
            if (np >= 1) begin
                chk({tag, ".seq0"}, 128'(out_entry[0].pc), 128'(next_pc_exp));
                next_pc_exp += 32'd4;
            end
            if (np == 2) begin
                chk({tag, ".seq1"}, 128'(out_entry[1].pc), 128'(next_pc_exp));
                next_pc_exp += 32'd4;
            end
        end
        if (!rst_n) begin
            model_q.delete();
            m_empty = '0;
            m_full  = '0;
        end else begin
            if (sz == 0 && m_empty != 32'hFFFF_FFFF) m_empty++;
            if (!rdy && m_full != 32'hFFFF_FFFF) m_full++;
            if (fl) begin
                model_q.delete();
            end else begin
                for (int k = 0; k < np; k++) void'(model_q.pop_front());
                if (rdy && iv[0]) model_q.push_back(a);
                if (rdy && iv == 2'b11) model_q.push_back(b);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    initial begin
        iq_entry_t ea;
        iq_entry_t eb;
        logic [31:0] pc_gen;

        resetn   = 1'b0;
        in_valid = '0;
        in_entry = '0;
        out_pop  = '0;
        flush    = 1'b0;
        model_q.delete();
        m_empty  = '0;
        m_full   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_all("reset");

        // Idle after reset: the empty counter tracks every cycle.
        for (int i = 0; i < 10; i++) idle("idle");
`ifdef IQ_PERF_EN
        chk("idle10.empty_cyc", 128'(empty_cycles), 128'(10));
`else
        chk("idle10.empty_cyc", 128'(empty_cycles), 128'(0));
`endif

        // Basic push of two then pop of two.
        ea = mk_entry(32'h1000);
        eb = mk_entry(32'h1004);
        step("push11", 1'b1, 2'b11, ea, eb, 2'b00, 1'b0);
        chk("push11.valid", 128'(out_valid), 128'(2'b11));
        chk("push11.pc0", 128'(out_entry[0].pc), 128'(32'h1000));
        chk("push11.pc1", 128'(out_entry[1].pc), 128'(32'h1004));
        step("pop11", 1'b1, 2'b00, '0, '0, 2'b11, 1'b0);
        chk("pop11.valid", 128'(out_valid), 128'(2'b00));

        // Fill to DEPTH, then a refused push.
        for (int i = 0; i < 4; i++) begin
            step("fill", 1'b1, 2'b11, mk_entry(32'h3000 + 32'(i * 8)),
                 mk_entry(32'h3004 + 32'(i * 8)), 2'b00, 1'b0);
            if (i == 2) chk("fill3.in_ready", 128'(in_ready), 128'(1'b1));
            if (i == 3) chk("fill4.in_ready", 128'(in_ready), 128'(1'b0));
        end
        step("full_push", 1'b1, 2'b11, mk_entry(32'hDEAD), mk_entry(32'hBEEF), 2'b00, 1'b0);
        chk("full_push.in_ready", 128'(in_ready), 128'(1'b0));
        chk("full_push.pc0", 128'(out_entry[0].pc), 128'(32'h3000));

        // Drain to 5, then flush with simultaneous push and pop.
        step("drain2", 1'b1, 2'b00, '0, '0, 2'b11, 1'b0);
        step("drain1", 1'b1, 2'b00, '0, '0, 2'b01, 1'b0);
        step("flush", 1'b1, 2'b11, mk_entry(32'h4000), mk_entry(32'h4004), 2'b11, 1'b1);
        chk("post_flush.valid", 128'(out_valid), 128'(2'b00));
        chk("post_flush.in_ready", 128'(in_ready), 128'(1'b1));

        // Illegal push "10" and illegal pop "10".
        step("ill_push", 1'b1, 2'b10, mk_entry(32'h5000), mk_entry(32'h5004), 2'b00, 1'b0);
        chk("ill_push.valid", 128'(out_valid), 128'(2'b00));
        ea = mk_entry(32'h6000);
        eb = mk_entry(32'h6004);
        step("push_ab", 1'b1, 2'b11, ea, eb, 2'b00, 1'b0);
        step("ill_pop", 1'b1, 2'b00, '0, '0, 2'b10, 1'b0);
        chk("ill_pop.entry0", 128'(out_entry[0]), 128'(ea));
        step("clear", 1'b1, 2'b00, '0, '0, 2'b11, 1'b0);

        // Odd pop with continuous pushes, wrapping the pointers many times.
        seq_chk     = 1;
        next_pc_exp = 32'h2000;
        pc_gen      = 32'h2000;
        for (int i = 0; i < 40; i++) begin
            ea = mk_entry(pc_gen);
            eb = mk_entry(pc_gen + 32'd4);
            if ((DEPTH - model_q.size()) >= 2) pc_gen += 32'd8;
            step("wrap", 1'b1, 2'b11, ea, eb, 2'b01, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) step("wrap_drain", 1'b1, 2'b00, '0, '0, 2'b11, 1'b0);
        chk("wrap.count_pc", 128'(next_pc_exp), 128'(pc_gen));
        seq_chk = 0;

        // Randomized traffic including flushes, illegal patterns and resets.
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                 mk_entry($urandom), mk_entry($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0));
        end

`ifdef IQ_PERF_EN
        // Saturation of the empty counter.
        step("sat_flush", 1'b1, 2'b00, '0, '0, 2'b00, 1'b1);
        dut.u_perf.empty_cycles_q = 32'hFFFF_FFFD;
        m_empty = 32'hFFFF_FFFD;
        for (int i = 0; i < 5; i++) idle("sat");
        chk("sat.empty_cyc", 128'(empty_cycles), 128'(32'hFFFF_FFFF));
`endif
        idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
